// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions for the counter and the display decoder.
//   DIGIT_W     : width of one BCD digit
//   BCD_MAX     : largest legal BCD digit value
//   count_op_e  : per-cycle operation selected by the counter's priority decode
//   bcd_sat()   : clamps a nibble to the legal BCD range (A-F become 9)
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int unsigned          DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0]   BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } count_op_e;

    function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_counter_if
// Control and data bundle of the cascaded BCD counter.
//   tick_in  : divided clock, sampled as data in the clkin domain
//   en       : count enable
//   up       : 1 = increment, 0 = decrement
//   clr      : synchronous clear
//   load     : synchronous parallel load of load_val
//   load_val : packed BCD load value, digit 0 in [3:0]
//   bcd      : packed BCD count, digit 0 least significant
//   wrap     : one-cycle pulse when the count wraps
//   step     : one-cycle pulse per executed count
// Modports: master drives controls / observes count; slave is the counter.
// -----------------------------------------------------------------------------
interface bcd_counter_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);

    logic                         tick_in;
    logic                         en;
    logic                         up;
    logic                         clr;
    logic                         load;
    logic [DIGIT_W*DIGITS-1:0]    load_val;
    logic [DIGIT_W*DIGITS-1:0]    bcd;
    logic                         wrap;
    logic                         step;

    modport master (
        output tick_in, en, up, clr, load, load_val,
        input  bcd, wrap, step
    );

    modport slave (
        input  tick_in, en, up, clr, load, load_val,
        output bcd, wrap, step
    );

endinterface

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit of the cascade with its own 4-bit register.
//   clkin, rst          : clock, asynchronous active-high reset
//   clr, load, ld_val   : synchronous clear / load (ld_val saturated to 9)
//   inc, dec            : step request from the previous stage (or the top)
//   digit               : current digit value
//   carry_out           : inc while at 9 (ripples to the next digit)
//   borrow_out          : dec while at 0 (ripples to the next digit)
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clkin,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               inc,
    input  logic               dec,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_out,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] r_digit;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= bcd_sat(ld_val);
        end else if (inc) begin
            r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + 4'd1;
        end else if (dec) begin
            r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    assign digit      = r_digit;
    assign carry_out  = inc & (r_digit == BCD_MAX);
    assign borrow_out = dec & (r_digit == '0);

endmodule

// File: rtl/bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// Cascaded DIGITS-digit BCD up/down counter advanced by rising edges of a
// divided clock that is treated purely as data in the clkin domain.
//   clkin : system clock (sole clock of the block)
//   rst   : asynchronous active-high reset
//   bus   : bcd_counter_if slave (tick_in/en/up/clr/load/load_val in,
//           bcd/wrap/step out)
// Priority per cycle: clr > load > count. A tick edge that cannot count in its
// own cycle is dropped, never deferred.
// -----------------------------------------------------------------------------
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
)(
    input  logic          clkin,
    input  logic          rst,
    bcd_counter_if.slave  bus
);

    logic                       r_tick_q;
    logic                       r_wrap;
    logic                       r_step;
    logic                       w_rise;
    count_op_e                  w_op;
    logic                       w_clr;
    logic                       w_load;
    // Index g feeds digit g; index DIGITS is the carry/borrow out of the top digit.
    logic [DIGITS:0]            w_inc;
    logic [DIGITS:0]            w_dec;
    logic [DIGIT_W*DIGITS-1:0]  w_bcd;

    // tick_q resets to 0, so a tick_in already high after reset counts once.
    assign w_rise = bus.tick_in & ~r_tick_q;

    always_comb begin
        w_op = OP_HOLD;
        if (bus.clr) begin
            w_op = OP_CLR;
        end else if (bus.load) begin
            w_op = OP_LOAD;
        end else if (w_rise & bus.en) begin
            w_op = bus.up ? OP_INC : OP_DEC;
        end
    end

    assign w_clr    = (w_op == OP_CLR);
    assign w_load   = (w_op == OP_LOAD);
    assign w_inc[0] = (w_op == OP_INC);
    assign w_dec[0] = (w_op == OP_DEC);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clkin      (clkin),
            .rst        (rst),
            .clr        (w_clr),
            .load       (w_load),
            .ld_val     (bus.load_val[g*DIGIT_W +: DIGIT_W]),
            .inc        (w_inc[g]),
            .dec        (w_dec[g]),
            .digit      (w_bcd[g*DIGIT_W +: DIGIT_W]),
            .carry_out  (w_inc[g+1]),
            .borrow_out (w_dec[g+1])
        );
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_tick_q <= 1'b0;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_tick_q <= bus.tick_in;
            r_step   <= w_inc[0] | w_dec[0];
            r_wrap   <= w_inc[DIGITS] | w_dec[DIGITS];
        end
    end

    assign bus.bcd  = w_bcd;
    assign bus.wrap = r_wrap;
    assign bus.step = r_step;

endmodule

// File: tb/tb_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter
// Scoreboard bench for the 4-digit bcd_counter. The driver applies one cycle
// of stimulus, advances an integer reference count (mod 10000) and queues the
// expected bcd/wrap/step for the following clkin edge; the monitor pops and
// compares on the falling edge once that clkin edge has occurred.
// -----------------------------------------------------------------------------
module tb_bcd_counter;

    localparam int unsigned ND  = 4;
    localparam int unsigned MOD = 10000;

    typedef struct {
        int unsigned tgt;
        logic [15:0] bcd;
        logic        wrap;
        logic        step;
    } exp_t;

    logic clkin;
    logic rst;
    bcd_counter_if #(.DIGITS(ND)) bus ();

    bcd_counter #(.DIGITS(ND)) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc_n = 0;
    int unsigned n_step_seen = 0;
    int unsigned n_wrap_seen = 0;

    // Reference state
    int unsigned m_count = 0;
    bit          m_prev  = 1'b0;
    bit          t_rst   = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic logic [15:0] to_bcd(int unsigned v);
        logic [15:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned from_load(logic [15:0] lv);
        int unsigned v;
        int unsigned nib;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            nib = int'(lv[i*4 +: 4]);
            if (nib > 9) nib = 9;
            v = v * 10 + nib;
        end
        return v;
    endfunction

    always @(posedge clkin) cyc_n++;

    always @(negedge clkin) begin
        exp_t e;
        if (bus.step === 1'b1) n_step_seen++;
        if (bus.wrap === 1'b1) n_wrap_seen++;
        while (sb.size() > 0 && sb[0].tgt <= cyc_n) begin
            e = sb.pop_front();
            chk("sb_bcd",  32'(bus.bcd),  32'(e.bcd));
            chk("sb_wrap", 32'(bus.wrap), 32'(e.wrap));
            chk("sb_step", 32'(bus.step), 32'(e.step));
        end
    end

    // One cycle of stimulus plus the reference step for the coming clkin edge.
    task automatic cyc(input bit tk, input bit e, input bit u, input bit c,
                       input bit l, input logic [15:0] lv);
        exp_t x;
        bit   rise;
        @(posedge clkin);
        #2;
        rst          = t_rst;
        bus.tick_in  = tk;
        bus.en       = e;
        bus.up       = u;
        bus.clr      = c;
        bus.load     = l;
        bus.load_val = lv;
        x.wrap = 1'b0;
        x.step = 1'b0;
        if (t_rst) begin
            m_count = 0;
            m_prev  = 1'b0;
        end else begin
            rise   = tk && !m_prev;
            m_prev = tk;
            if (c) begin
                m_count = 0;
            end else if (l) begin
                m_count = from_load(lv);
            end else if (rise && e) begin
                x.step = 1'b1;
                if (u) begin
                    if (m_count == MOD - 1) x.wrap = 1'b1;
                    m_count = (m_count + 1) % MOD;
                end else if (m_count == 0) begin
                    x.wrap  = 1'b1;
                    m_count = MOD - 1;
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
        x.tgt = cyc_n + 1;
        x.bcd = to_bcd(m_count);
        sb.push_back(x);
    endtask

    task automatic ticks(input int unsigned n, input int unsigned hi,
                         input int unsigned lo, input bit e, input bit u);
        for (int unsigned i = 0; i < n; i++) begin
            for (int unsigned j = 0; j < hi; j++) cyc(1'b1, e, u, 1'b0, 1'b0, 16'h0);
            for (int unsigned j = 0; j < lo; j++) cyc(1'b0, e, u, 1'b0, 1'b0, 16'h0);
        end
    endtask

    task automatic do_load(input logic [15:0] lv);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lv);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        int unsigned s0;
        int unsigned w0;
        exp_t        z;

        rst          = 1'b1;
        bus.tick_in  = 1'b0;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // Reset
        t_rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("reset_bcd",  32'(bus.bcd),  32'h0);
        chk("reset_wrap", 32'(bus.wrap), 32'h0);
        chk("reset_step", 32'(bus.step), 32'h0);
        t_rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

        // 12 ticks up
        s0 = n_step_seen;
        w0 = n_wrap_seen;
        ticks(12, 5, 5, 1'b1, 1'b1);
        chk("up12_bcd",   32'(bus.bcd), 32'h0012);
        chk("up12_steps", n_step_seen - s0, 12);
        chk("up12_wraps", n_wrap_seen - w0, 0);

        // 9998 + 2 -> 0000 with wrap
        do_load(16'h9998);
        w0 = n_wrap_seen;
        ticks(2, 3, 3, 1'b1, 1'b1);
        chk("upwrap_bcd",   32'(bus.bcd), 32'h0000);
        chk("upwrap_wraps", n_wrap_seen - w0, 1);

        // 0000 - 1 -> 9999 with wrap, then 9998
        do_load(16'h0000);
        w0 = n_wrap_seen;
        ticks(1, 3, 3, 1'b1, 1'b0);
        chk("dnwrap_bcd",   32'(bus.bcd), 32'h9999);
        chk("dnwrap_wraps", n_wrap_seen - w0, 1);
        ticks(1, 3, 3, 1'b1, 1'b0);
        chk("dn_bcd",       32'(bus.bcd), 32'h9998);
        chk("dn_wraps",     n_wrap_seen - w0, 1);

        // Load saturation
        do_load(16'h1A3F);
        chk("sat_bcd", 32'(bus.bcd), 32'h1939);

        // clr wins over a coincident tick edge
        do_load(16'h0457);
        s0 = n_step_seen;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("clr_bcd",   32'(bus.bcd), 32'h0);
        chk("clr_steps", n_step_seen - s0, 0);
        // tick with en=0
        ticks(1, 3, 3, 1'b0, 1'b1);
        chk("noen_bcd", 32'(bus.bcd), 32'h0);
        // 30-cycle-high tick
        s0 = n_step_seen;
        ticks(1, 30, 3, 1'b1, 1'b1);
        chk("hold_bcd",   32'(bus.bcd), 32'h0001);
        chk("hold_steps", n_step_seen - s0, 1);

        // Asynchronous reset between clkin edges at 0321
        do_load(16'h0321);
        ticks(1, 1, 3, 1'b0, 1'b1);
        @(posedge clkin);
        #2;
        bus.tick_in = 1'b1;
        bus.en      = 1'b1;
        m_count     = 0;
        m_prev      = 1'b0;
        z.tgt  = cyc_n + 1;
        z.bcd  = '0;
        z.wrap = 1'b0;
        z.step = 1'b0;
        sb.push_back(z);
        #4;
        chk("pre_rst_bcd", 32'(bus.bcd), 32'h0321);
        rst = 1'b1;
        #1;
        chk("arst_bcd",  32'(bus.bcd),  32'h0);
        chk("arst_wrap", 32'(bus.wrap), 32'h0);
        chk("arst_step", 32'(bus.step), 32'h0);
        t_rst = 1'b1;
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        t_rst = 1'b0;
        s0 = n_step_seen;
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("rel_bcd",   32'(bus.bcd), 32'h0001);
        chk("rel_steps", n_step_seen - s0, 1);

        // Randomised traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 39) == 0),
                16'($urandom));
        end

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clkin);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
